// File: rtl/gate_truth_table_scanner_pkg.sv
// Shared types for the gate truth-table scanner: FSM encoding and table sizing.
package gate_scan_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} scan_state_t;

  localparam int MAX_N_IN = 4;

  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/gate_truth_table_scanner_if.sv
// Stimulus/response and result-handshake bundle between the scanner (master) and its environment (slave).
interface gate_truth_table_scanner_if
  import gate_scan_pkg::*;
#(
  parameter int N_IN = 2
);

  localparam int TT_W = tt_width(N_IN);

  logic            start;
  logic            busy;
  logic [N_IN-1:0] stim;
  logic            resp;
  logic [TT_W-1:0] expect_tt;
  logic            out_valid;
  logic            out_ready;
  logic [TT_W-1:0] tt;
  logic            match;

  modport master (
    input  start, resp, expect_tt, out_ready,
    output busy, stim, out_valid, tt, match
  );

  modport slave (
    output start, resp, expect_tt, out_ready,
    input  busy, stim, out_valid, tt, match
  );

endinterface

// File: rtl/gate_truth_table_scanner_settle_timer.sv
// Per-combination settle counter; tick marks the edge on which resp is sampled.
module settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  logic [3:0] count_q, count_d;

  // Combinational tick so SETTLE==1 samples on every edge with no extra delay.
  assign tick = (count_q == 4'(SETTLE - 1));

  always_comb begin
    count_d = count_q + 4'd1;
    if (clear || tick) count_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/gate_truth_table_scanner.sv
// Sweeps every input combination through an external gate, captures its truth table and reports a match.
module gate_truth_table_scanner
  import gate_scan_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  gate_truth_table_scanner_if.master  bus
);

  localparam int TT_W = tt_width(N_IN);

  scan_state_t     state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [TT_W-1:0] tt_q, tt_d;
  logic            match_q, match_d;
  logic            valid_q, valid_d;
  logic            tick;

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q != DRIVE),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    tt_d    = tt_q;
    match_d = match_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = DRIVE;
          stim_d  = '0;
          tt_d    = '0;
        end
      end
      DRIVE: begin
        if (tick) begin
          tt_d[stim_q] = bus.resp;
          // Last combination is detected by value so stim never wraps back to zero.
          if (stim_q != '1) begin
            stim_d = stim_q + N_IN'(1);
          end else begin
            state_d = DONE;
            valid_d = 1'b1;
            match_d = (tt_d == bus.expect_tt);
          end
        end
      end
      DONE: begin
        if (valid_q && bus.out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stim_q  <= '0;
      tt_q    <= '0;
      match_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      tt_q    <= tt_d;
      match_q <= match_d;
      valid_q <= valid_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.stim      = stim_q;
  assign bus.tt        = tt_q;
  assign bus.match     = match_q;
  assign bus.out_valid = valid_q;

endmodule
